// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared extension modes and FIFO depth for the immediate-extension unit
package imm_ext_pkg;
  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BOFF} ext_mode_t;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/imm_ext_pipe_core.sv
// imm_ext_core: combinational immediate widening in zero, sign, load-upper and branch-offset modes
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext
);
  logic [OUT_W-1:0] zx, sx;
  always_comb begin
    zx  = OUT_W'(imm);
    sx  = OUT_W'($signed(imm));
    ext = mode == EXT_ZERO ? zx :
          mode == EXT_SIGN ? sx :
          mode == EXT_LUI  ? zx << (OUT_W - IN_W) : sx << 2;
  end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender behind a 2-entry valid/ready FIFO with transfer counter
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [OUT_W-1:0] ext;
  logic             rd_ptr, wr_ptr, push, pop;
  logic [1:0]       count, count_next;
  if (IN_W < 1 || OUT_W < IN_W) begin : g_bad_params
    $error("imm_ext_pipe: parameters require 1 <= IN_W <= OUT_W");
  end
  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm (in_imm),
    .mode(ext_mode_t'(in_mode)),
    .ext (ext)
  );
  always_comb begin
    push       = in_valid & in_ready;
    out_valid  = count != 2'd0;
    pop        = out_valid & out_ready;
    out_data   = out_valid ? mem[rd_ptr] : '0;
    count_next = count + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ext;
  end
  // in_ready is registered from the next count so it never follows out_ready combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
      xfer_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      count    <= count_next;
      in_ready <= count_next < 2'(FIFO_DEPTH);
    end
  end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: scoreboard bench for imm_ext_pipe with random traffic and a 12-bit variant
module tb_imm_ext_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [31:0] out_data;
  logic [7:0]  xfer_cnt;
  logic        s_reset = 1'b1, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic        s_in_ready, s_out_valid;
  logic [11:0] s_in_imm = '0, s_out_data;
  logic [1:0]  s_in_mode = '0, s_xfer_cnt;
  logic [31:0] q[$];
  logic [7:0]  exp_x = '0;
  int          total = 0, bad = 0;
  bit          prod_done = 1'b0;

  always #5 clk = ~clk;

  imm_ext_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(12), .CNT_W(2)) u_small (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_imm(s_in_imm), .in_mode(s_in_mode), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .xfer_cnt(s_xfer_cnt)
  );

  function automatic logic [31:0] model(logic [15:0] imm, logic [1:0] m);
    longint u = longint'(imm);
    longint s = imm[15] ? u - 65536 : u;
    longint r = m == 2'd0 ? u : m == 2'd1 ? s : m == 2'd2 ? u * 65536 : s * 4;
    return 32'(r);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    exp_x = '0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic send(logic [15:0] imm, logic [1:0] m);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = m;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (in_ready) begin
        q.push_back(model(imm, m));
        ok = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) step();
    check("drain", 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stale_entry got=%h want=none", out_data);
        end else begin
          check("data", out_data, q[0]);
          if (out_ready) begin
            check("xfer", 32'(xfer_cnt), 32'(exp_x));
            void'(q.pop_front());
            exp_x++;
          end
        end
      end else begin
        check("idle_data", out_data, 32'd0);
      end
    end
  end

  initial begin
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_xfer", 32'(xfer_cnt), 32'd0);

    out_ready = 1'b1;
    send(16'h8001, 2'd0); check("zero", out_data, 32'h00008001);
    send(16'h8001, 2'd1); check("sign", out_data, 32'hFFFF8001);
    send(16'h8001, 2'd2); check("lui", out_data, 32'h80010000);
    send(16'hFFFF, 2'd3); check("boff", out_data, 32'hFFFFFFFC);
    drain();

    do_reset();
    out_ready = 1'b0;
    send(16'd1, 2'd1);
    check("bp_ready1", 32'(in_ready), 32'd1);
    send(16'd2, 2'd1);
    check("bp_full", 32'(in_ready), 32'd0);
    fork
      send(16'd3, 2'd1);
      begin
        repeat (3) step();
        check("bp_hold", out_data, 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_xfer", 32'(xfer_cnt), 32'd3);

    out_ready = 1'b0;
    send(16'h00A5, 2'd0);
    out_ready = 1'b1;
    send(16'hF00F, 2'd1);
    check("pp_valid", 32'(out_valid), 32'd1);
    check("pp_data", out_data, 32'hFFFFF00F);
    check("pp_ready", 32'(in_ready), 32'd1);
    drain();

    out_ready = 1'b0;
    send(16'h1234, 2'd2);
    send(16'h5678, 2'd3);
    check("mid_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    q.delete();
    exp_x = '0;
    step();
    reset = 1'b0;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_xfer", 32'(xfer_cnt), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) step();

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(16'($urandom), 2'($urandom_range(0, 3)));
          repeat ($urandom_range(0, 2)) step();
        end
        prod_done = 1'b1;
      end
      while (!prod_done) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    join
    drain();

    s_out_ready = 1'b1;
    repeat (2) step();
    s_reset = 1'b0;
    check("s_rst_xfer", 32'(s_xfer_cnt), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      s_in_valid = 1'b1;
      s_in_imm   = i == 1 ? 12'h800 : 12'($urandom);
      s_in_mode  = i == 1 ? 2'd2 : 2'($urandom_range(0, 3));
      step();
      s_in_valid = 1'b0;
      check("s_valid", 32'(s_out_valid), 32'd1);
      if (i == 1) check("s_lui", 32'(s_out_data), 32'h800);
      step();
      check("s_xfer", 32'(s_xfer_cnt), 32'(i % 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
